bin_vec_seq: RTL and testbench

BIN_VEC_SEQ -- requirements
Module: bin_vec_seq

---
 rtl/bin_vec_seq.sv | 100 ++++++++++
 tb/tb_bin_vec_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_vec_seq.sv
// bin_vec_seq: walks every WIDTH-bit vector into a binary gate,
// holds each one, then checks the gate response and reports pass/fail.
module bin_vec_seq #(
  parameter int WIDTH       = 2,
  parameter int HOLD_CYCLES = 20,
  parameter int INVERT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] io_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] vec_q;
  logic [WIDTH-1:0] vec_d;
  logic [WIDTH-1:0] expect_v;
  logic [15:0]      hold_q;
  logic [15:0]      hold_d;
  logic [7:0]       err_d;
  logic             pass_d;
  logic [WIDTH-1:0] io_in_d;

  // Next state, counters, response check and status outputs
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    hold_d   = hold_q;
    err_d    = err_cnt;
    pass_d   = pass;
    busy     = 1'b0;
    done     = 1'b0;
    expect_v = (INVERT != 0) ? ~vec_q : vec_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
        end
      end
      DRIVE: begin
        busy   = 1'b1;
        hold_d = hold_q + 16'd1;
        if (hold_q == HOLD_LAST) begin
          if (io_out != expect_v && err_cnt != 8'hff)
            err_d = err_cnt + 8'd1;
          if (vec_q != '1) begin
            vec_d  = vec_q + 1'b1;
            hold_d = '0;
          end else begin
            state_d = DONE;
            pass_d  = (err_d == 8'd0);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    io_in_d = (state_d == DRIVE) ? vec_d : '0;
  end

  // State and datapath registers; io_in is registered to stay glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      io_in   <= '0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      io_in   <= io_in_d;
      pass    <= pass_d;
      err_cnt <= err_d;
    end
  end

endmodule

// File: tb/tb_bin_vec_seq.sv
// tb_bin_vec_seq: directed checks of the vector sequencer in three
// configurations with hand-computed expectations.
module tb_bin_vec_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       stuck;
  logic       start0;
  logic       start1;
  logic       start2;
  logic [1:0] io_in0;
  logic [1:0] io_out0;
  logic       busy0;
  logic       done0;
  logic       pass0;
  logic [7:0] err0;
  logic [1:0] io_in1;
  logic [1:0] io_out1;
  logic       busy1;
  logic       done1;
  logic       pass1;
  logic [7:0] err1;
  logic [7:0] io_in2;
  logic [7:0] io_out2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [7:0] err2;

  int checks = 0;
  int failures = 0;
  int n;
  int seen;

  always #5 clk = ~clk;

  assign io_out0 = stuck ? 2'b00 : ~io_in0;
  assign io_out1 = ~io_in1;
  assign io_out2 = ~io_in2;

  bin_vec_seq #(.WIDTH(2), .HOLD_CYCLES(20), .INVERT(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .io_in(io_in0),
    .io_out(io_out0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0)
  );

  bin_vec_seq #(.WIDTH(2), .HOLD_CYCLES(1), .INVERT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .io_in(io_in1),
    .io_out(io_out1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1)
  );

  bin_vec_seq #(.WIDTH(8), .HOLD_CYCLES(2), .INVERT(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .io_in(io_in2),
    .io_out(io_out2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    stuck = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_io_in", 32'(io_in0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_pass", 32'(pass0), 0);
    check("rst_err", 32'(err0), 0);

    // good inverter, full run
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 0;
    check("t1_busy", 32'(busy0), 1);
    while (!done0 && n < 200) begin
      if (n == 0 || n == 19 || n == 20 || n == 59 || n == 60 || n == 79)
        check($sformatf("t1_io_in_%0d", n), 32'(io_in0), n / 20);
      step();
      n++;
    end
    check("t1_latency", n, 80);
    check("t1_busy_done", 32'(busy0), 0);
    check("t1_io_in_done", 32'(io_in0), 0);
    check("t1_err", 32'(err0), 0);
    check("t1_pass", 32'(pass0), 1);
    step();
    check("t1_done_pulse", 32'(done0), 0);
    check("t1_pass_hold", 32'(pass0), 1);

    // response stuck at 00
    stuck = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 0;
    check("t2_pass_hold", 32'(pass0), 1);
    while (!done0 && n < 200) begin
      if (n == 20) check("t2_err_20", 32'(err0), 1);
      if (n == 40) check("t2_err_40", 32'(err0), 2);
      if (n == 60) check("t2_err_60", 32'(err0), 3);
      step();
      n++;
    end
    check("t2_latency", n, 80);
    check("t2_err", 32'(err0), 3);
    check("t2_pass", 32'(pass0), 0);
    step();
    stuck = 1'b0;

    // second start mid-run is ignored
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 200) begin
      if (n == 30) start0 = 1'b1;
      step();
      n++;
      start0 = 1'b0;
    end
    check("t3_latency", n, 80);
    check("t3_pass", 32'(pass0), 1);
    check("t3_err", 32'(err0), 0);
    step();
    check("t3_no_queue_a", 32'(busy0), 0);
    step();
    check("t3_no_queue_b", 32'(busy0), 0);

    // reset mid-run aborts without done
    stuck = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 0;
    while (n < 45) begin
      step();
      n++;
    end
    check("t4_err_pre", 32'(err0), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_io_in", 32'(io_in0), 0);
    check("t4_busy", 32'(busy0), 0);
    check("t4_err", 32'(err0), 0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done0) seen++;
      step();
    end
    check("t4_no_done", seen, 0);
    stuck = 1'b0;
    start0 = 1'b1;
    step();
    n = 0;
    while (!done0 && n < 200) begin
      step();
      n++;
    end
    check("t4_latency", n, 80);
    check("t4_pass", 32'(pass0), 1);
    step();
    check("t4_idle", 32'(busy0), 0);
    step();
    check("t4_restart", 32'(busy0), 1);
    start0 = 1'b0;
    check("t4_restart_err", 32'(err0), 0);
    n = 0;
    while (!done0 && n < 200) begin
      step();
      n++;
    end
    check("t4_rerun_latency", n, 80);
    check("t4_rerun_pass", 32'(pass0), 1);

    // one cycle per vector
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin
      if (n < 4) check($sformatf("t5_io_in_%0d", n), 32'(io_in1), n);
      step();
      n++;
    end
    check("t5_latency", n, 4);
    check("t5_pass", 32'(pass1), 1);
    check("t5_err", 32'(err1), 0);

    // 8-bit, non-inverting expectation against inverter: saturation
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 1000) begin
      if (n == 2) check("t6_err_first", 32'(err2), 1);
      step();
      n++;
    end
    check("t6_latency", n, 512);
    check("t6_err", 32'(err2), 255);
    check("t6_pass", 32'(pass2), 0);
    check("t6_busy", 32'(busy2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
